// File: rtl/ste_edge_pkg.sv
// Shared types and helpers for the multi-channel debounced edge detector.
package ste_edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // All-ones value of a w-bit saturating counter.
  function automatic int unsigned sat_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/ste_edge_deb_ch.sv
// One channel: input synchroniser, debounce filter and polarity-qualified edge pulse.
module ste_edge_deb_ch
  import ste_edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic             clk,
  input  logic             reset_ni,
  input  logic             din_i,
  input  edge_mode_e       mode_i,
  input  logic [DEB_W-1:0] deb_len_i,
  output logic             level_o,
  output logic             edge_o
);

  logic             sync;
  logic             flt, flt_dly;
  logic [DEB_W-1:0] dcnt;
  logic             rise, fall;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync = din_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] chain;
    always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
        chain <= '0;
      end else begin
        chain[0] <= din_i;
        for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      end
    end
    assign sync = chain[SYNC_STAGES-1];
  end

  // >= (not ==) so a shortened deb_len_i mid-count commits on the next cycle.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      flt     <= 1'b0;
      flt_dly <= 1'b0;
      dcnt    <= '0;
    end else begin
      flt_dly <= flt;
      if (sync == flt) begin
        dcnt <= '0;
      end else if (dcnt >= deb_len_i) begin
        flt  <= sync;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DEB_W'(1);
      end
    end
  end

  assign rise    = flt & ~flt_dly;
  assign fall    = ~flt & flt_dly;
  assign level_o = flt;

  always_comb begin
    edge_o = 1'b0;
    case (mode_i)
      EDGE_RISE: edge_o = rise;
      EDGE_FALL: edge_o = fall;
      EDGE_BOTH: edge_o = rise | fall;
      default:   edge_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ste_edge_deb.sv
// Multi-channel debounced edge detector with sticky pending flags and combined irq.
// Define STE_EDGE_CNT_EN to add per-channel saturating event counters on cnt_o.
module ste_edge_deb
  import ste_edge_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset_ni,
  input  logic [CH-1:0]       din_i,
  input  logic [2*CH-1:0]     mode_i,
  input  logic [DEB_W-1:0]    deb_len_i,
  input  logic [CH-1:0]       pend_clr_i,
  output logic [CH-1:0]       level_o,
  output logic [CH-1:0]       edge_o,
  output logic [CH-1:0]       pend_o,
`ifdef STE_EDGE_CNT_EN
  output logic [CH*CNT_W-1:0] cnt_o,
`endif
  output logic                irq_o
);

  logic [CH-1:0] pend_q;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    ste_edge_deb_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_W      (DEB_W)
    ) u_ch (
      .clk      (clk),
      .reset_ni (reset_ni),
      .din_i    (din_i[g]),
      .mode_i   (edge_mode_e'(mode_i[2*g +: 2])),
      .deb_len_i(deb_len_i),
      .level_o  (level_o[g]),
      .edge_o   (edge_o[g])
    );
  end

  // Set beats clear so an edge coinciding with a clear is never lost.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) pend_q <= '0;
    else           pend_q <= edge_o | (pend_q & ~pend_clr_i);
  end

  assign pend_o = pend_q;
  assign irq_o  = |pend_q;

`ifdef STE_EDGE_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(sat_max(CNT_W));

  logic [CH-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (pend_clr_i[c])                       cnt_q[c] <= edge_o[c] ? CNT_W'(1) : '0;
        else if (edge_o[c] && cnt_q[c] != CntMax) cnt_q[c] <= cnt_q[c] + CNT_W'(1);
      end
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_ste_edge_deb.sv
// Bench for ste_edge_deb: two instances (SYNC_STAGES=2 and 0) on shared stimulus,
// checked every cycle against a window-based debounce model, plus directed cases.
module tb_ste_edge_deb;
  localparam int CH = 4, DEB_W = 8, CNT_W = 2;
  localparam int SA = 2, SB = 0;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk = ~clk;

  logic [CH-1:0]    din_i = '0, pend_clr_i = '0;
  logic [2*CH-1:0]  mode_i = '0;
  logic [DEB_W-1:0] deb_len_i = '0;
  logic [CH-1:0]    level_a, edge_a, pend_a, level_b, edge_b, pend_b;
  logic             irq_a, irq_b;
`ifdef STE_EDGE_CNT_EN
  logic [CH*CNT_W-1:0] cnt_a, cnt_b;
`endif

  ste_edge_deb #(.CH(CH), .SYNC_STAGES(SA), .DEB_W(DEB_W), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .reset_ni(reset_ni), .din_i(din_i), .mode_i(mode_i), .deb_len_i(deb_len_i),
    .pend_clr_i(pend_clr_i), .level_o(level_a), .edge_o(edge_a), .pend_o(pend_a),
`ifdef STE_EDGE_CNT_EN
    .cnt_o(cnt_a),
`endif
    .irq_o(irq_a));

  ste_edge_deb #(.CH(CH), .SYNC_STAGES(SB), .DEB_W(DEB_W), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .reset_ni(reset_ni), .din_i(din_i), .mode_i(mode_i), .deb_len_i(deb_len_i),
    .pend_clr_i(pend_clr_i), .level_o(level_b), .edge_o(edge_b), .pend_o(pend_b),
`ifdef STE_EDGE_CNT_EN
    .cnt_o(cnt_b),
`endif
    .irq_o(irq_b));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the filtered level flips once the last deb_len+1 synchronised
  // samples all disagree with it; sync is the raw input seen S clocks late.
  bit [CH-1:0] dh[$], sh0[$], sh1[$];
  bit [CH-1:0] m_flt[2], m_fltd[2], m_pend[2];
  int          m_cnt[2][CH];

  task automatic model_reset();
    dh.delete(); sh0.delete(); sh1.delete();
    repeat (4) dh.push_back('0);
    repeat (20) begin sh0.push_back('0); sh1.push_back('0); end
    for (int d = 0; d < 2; d++) begin
      m_flt[d] = '0; m_fltd[d] = '0; m_pend[d] = '0;
      for (int c = 0; c < CH; c++) m_cnt[d][c] = 0;
    end
  endtask

  function automatic bit [CH-1:0] qual(input bit [CH-1:0] f, input bit [CH-1:0] fd);
    bit [CH-1:0] q = '0;
    for (int c = 0; c < CH; c++)
      q[c] = (f[c] && !fd[c] && mode_i[2*c]) || (!f[c] && fd[c] && mode_i[2*c+1]);
    return q;
  endfunction

  function automatic bit held(input int d, input int c, input int len, input bit v);
    bit [CH-1:0] s;
    for (int i = 0; i <= len; i++) begin
      s = (d == 0) ? sh0[sh0.size()-1-i] : sh1[sh1.size()-1-i];
      if (s[c] != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      model_reset();
    end else begin
      bit [CH-1:0] e, sy;
      dh.push_back(din_i);
      if (dh.size() > 8) void'(dh.pop_front());
      for (int d = 0; d < 2; d++) begin
        sy = dh[dh.size()-1-((d == 0) ? SA : SB)];
        if (d == 0) begin sh0.push_back(sy); if (sh0.size() > 40) void'(sh0.pop_front()); end
        else        begin sh1.push_back(sy); if (sh1.size() > 40) void'(sh1.pop_front()); end
        e = qual(m_flt[d], m_fltd[d]);
        for (int c = 0; c < CH; c++) begin
          if (e[c]) m_pend[d][c] = 1'b1;
          else if (pend_clr_i[c]) m_pend[d][c] = 1'b0;
          if (pend_clr_i[c]) m_cnt[d][c] = e[c] ? 1 : 0;
          else if (e[c] && m_cnt[d][c] < (1 << CNT_W) - 1) m_cnt[d][c]++;
        end
        m_fltd[d] = m_flt[d];
        for (int c = 0; c < CH; c++)
          if (held(d, c, int'(deb_len_i), !m_flt[d][c])) m_flt[d][c] = !m_flt[d][c];
      end
    end
  end

  task automatic check_all();
    chk("level_a", level_a, m_flt[0]);
    chk("edge_a", edge_a, qual(m_flt[0], m_fltd[0]));
    chk("pend_a", pend_a, m_pend[0]);
    chk("irq_a", irq_a, |m_pend[0]);
    chk("level_b", level_b, m_flt[1]);
    chk("edge_b", edge_b, qual(m_flt[1], m_fltd[1]));
    chk("pend_b", pend_b, m_pend[1]);
    chk("irq_b", irq_b, |m_pend[1]);
`ifdef STE_EDGE_CNT_EN
    for (int c = 0; c < CH; c++) begin
      chk("cnt_a", cnt_a[c*CNT_W +: CNT_W], m_cnt[0][c]);
      chk("cnt_b", cnt_b[c*CNT_W +: CNT_W], m_cnt[1][c]);
    end
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    int         ch;
    logic [1:0] mode;
    int         len;
    int         edges;
    bit         seen;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   ne;
    bit   seen, found;

    tbl[0] = '{ch: 1, mode: 2'b11, len: 3,  edges: 0, seen: 1'b0};
    tbl[1] = '{ch: 1, mode: 2'b11, len: 4,  edges: 2, seen: 1'b1};
    tbl[2] = '{ch: 2, mode: 2'b10, len: 10, edges: 1, seen: 1'b1};
    tbl[3] = '{ch: 2, mode: 2'b00, len: 10, edges: 0, seen: 1'b1};
    tbl[4] = '{ch: 0, mode: 2'b01, len: 8,  edges: 1, seen: 1'b1};

    model_reset();
    repeat (2) tick();
    chk("rst_level", {level_a, level_b}, 0);
    chk("rst_edge", {edge_a, edge_b}, 0);
    chk("rst_pend", {pend_a, pend_b}, 0);
    chk("rst_irq", {irq_a, irq_b}, 0);
    reset_ni = 1'b1;
    tick();

    // Rise latency: S + deb_len clocks after first sampling edge, one cycle wide.
    deb_len_i = 3;
    mode_i    = 8'h01;
    din_i[0]  = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("lat_a", edge_a[0], i == 6);
      chk("lat_b", edge_b[0], i == 4);
    end
    chk("lat_pend", pend_a[0], 1);
    chk("lat_irq", irq_a, 1);

    // Clear coinciding with a new edge: set wins; clear alone then empties it.
    mode_i[1:0] = 2'b11;
    din_i[0]    = 1'b0;
    found       = 1'b0;
    for (int i = 0; i < 15 && !found; i++) begin
      tick();
      if (edge_a[0]) found = 1'b1;
    end
    chk("coll_found", found, 1);
    pend_clr_i[0] = 1'b1;
    tick();
    chk("coll_set_wins", pend_a[0], 1);
    tick();
    chk("clr_pend", pend_a[0], 0);
    chk("clr_irq", irq_a, 0);
    pend_clr_i = '0;

    // Pulse table: glitch rejection and polarity qualification.
    foreach (tbl[r]) begin
      mode_i[2*tbl[r].ch +: 2] = tbl[r].mode;
      din_i[tbl[r].ch] = 1'b1;
      ne = 0;
      seen = 1'b0;
      for (int i = 0; i < tbl[r].len + 20; i++) begin
        tick();
        if (i == tbl[r].len - 1) din_i[tbl[r].ch] = 1'b0;
        ne += int'(edge_a[tbl[r].ch]);
        seen |= level_a[tbl[r].ch];
      end
      chk($sformatf("tbl%0d_edges", r), ne, tbl[r].edges);
      chk($sformatf("tbl%0d_level", r), seen, tbl[r].seen);
      chk($sformatf("tbl%0d_pend", r), pend_a[tbl[r].ch], tbl[r].edges > 0);
      pend_clr_i = '1;
      tick();
      pend_clr_i = '0;
    end

    // No filtering: unsynchronised instance pulses one cycle after each change.
    deb_len_i   = 0;
    mode_i[7:6] = 2'b11;
    for (int t = 0; t < 5; t++) begin
      din_i[3] = ~din_i[3];
      tick();
      chk("tog_b", edge_b[3], 1);
      tick();
      chk("tog_b_gap", edge_b[3], 0);
    end
    repeat (5) tick();
`ifdef STE_EDGE_CNT_EN
    chk("cnt_sat_a", cnt_a[3*CNT_W +: CNT_W], 3);
    chk("cnt_sat_b", cnt_b[3*CNT_W +: CNT_W], 3);
    pend_clr_i = 4'b1000;
    tick();
    pend_clr_i = '0;
    chk("cnt_clr_a", cnt_a[3*CNT_W +: CNT_W], 0);
    chk("cnt_clr_b", cnt_b[3*CNT_W +: CNT_W], 0);
`endif

    // Reset in the middle of a debounce count.
    deb_len_i = 10;
    din_i[1]  = 1'b1;
    repeat (5) tick();
    #2 reset_ni = 1'b0;
    #1;
    chk("mid_rst_level", {level_a, level_b}, 0);
    chk("mid_rst_edge", {edge_a, edge_b}, 0);
    chk("mid_rst_pend", {pend_a, pend_b}, 0);
    chk("mid_rst_irq", {irq_a, irq_b}, 0);
    din_i = '0;
    tick();
    reset_ni = 1'b1;
    ne = 0;
    repeat (25) begin
      tick();
      ne += int'(|{edge_a, edge_b, level_a, level_b});
    end
    chk("post_rst_quiet", ne, 0);

    // Random traffic against the model.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 250 == 0) begin
        deb_len_i = DEB_W'($urandom_range(0, 5));
        mode_i    = (2*CH)'($urandom);
      end
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) din_i[c] = ~din_i[c];
      pend_clr_i = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ste_edge_deb.md
Name: ste_edge_deb

Overview:
Multi-channel, parametrised edge detector with a configurable synchroniser depth and a per-channel debounce (glitch) filter. Edge polarity is selectable per channel at run time. Each channel provides a one-cycle edge pulse, a sticky pending flag with clear, and a combined interrupt. It sits between raw board inputs (buttons, dice trigger) and control FSMs, replacing single-channel detect-only edge logic.

Parameters:
CH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel; 0 = input already synchronous, used combinationally
DEB_W, 8, width of debounce length and counter
CNT_W, 8, width of the per-channel event counter (used only with STE_EDGE_CNT_EN)

Ports:
clk  input  1  system clock
reset_ni  input  1  asynchronous, active-low reset
din_i  input  CH  raw input levels
mode_i  input  2*CH  per-channel mode, channel n at [2n+1:2n]: 00 off, 01 rise, 10 fall, 11 both
deb_len_i  input  DEB_W  required stable cycles minus one, shared by all channels
pend_clr_i  input  CH  clear pending flag (and event counter), one bit per channel
level_o  output  CH  debounced (filtered) level
edge_o  output  CH  one-cycle pulse per qualified edge
pend_o  output  CH  sticky pending flags
irq_o  output  1  OR of pend_o
cnt_o  output  CH*CNT_W  event counters (only with STE_EDGE_CNT_EN)

Behaviour:
- Reset values: sync chain, filtered level flt, flt_dly, debounce counter dcnt, pend, and event counters are all 0. level_o, edge_o, pend_o, irq_o, cnt_o are all 0.
- Synchroniser: shift chain of SYNC_STAGES flops. sync = last stage, or din_i when SYNC_STAGES = 0.
- Debounce, evaluated per channel each cycle:
  - If sync == flt: dcnt <= 0.
  - Else if dcnt >= deb_len_i: flt <= sync, dcnt <= 0.
  - Else: dcnt <= dcnt + 1.
- level_o = flt.
- A level differing from flt for fewer than deb_len_i+1 consecutive cycles is discarded.
- deb_len_i changes take effect immediately. The >= compare guarantees that shortening deb_len_i mid-count commits on the next cycle.
- Latency: if din_i changes and is first sampled at edge k and stays stable, flt updates at edge k+SYNC_STAGES+deb_len_i. edge_o is high for exactly the following cycle.
- Edge detection: flt_dly <= flt each cycle.
  - rise = flt & ~flt_dly; fall = ~flt & flt_dly.
  - edge_o = (rise & mode[0]) | (fall & mode[1]), using the current mode_i. No edge is issued in mode 00.
- Mode changes never alter flt, dcnt or pend; only subsequent edge qualification is affected.
- Pending flag:
  - pend <= 1 on edge_o.
  - Else pend <= 0 when pend_clr_i is set.
  - Simultaneous set and clear: set wins, so no event is lost.
- irq_o is combinational |pend.
- Reset mid-operation clears everything asynchronously; no edge_o is generated by the reset itself.
- If din_i is high through reset release, a rising edge is reported SYNC_STAGES+deb_len_i cycles after release. This is intended and follows from the reset value 0.
- Channels are fully independent apart from the shared deb_len_i.

Optional Feature:
STE_EDGE_CNT_EN
- Defined: adds port cnt_o. Each channel has a CNT_W-bit counter that increments on edge_o and saturates at all-ones. pend_clr_i resets the counter to 0; on simultaneous clear and edge_o the result is 1.
- Not defined: cnt_o port and counters are absent. All other behaviour is identical.

Decomposition:
- Package ste_edge_pkg:
  - typedef enum logic [1:0] edge_mode_e {EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11}.
  - Helper constant for the saturating count maximum.
- Sub-module ste_edge_deb_ch: one channel covering synchroniser, debounce counter, flt/flt_dly and edge qualification.
- The top generates CH instances and holds pend, irq and the optional counters.

Test Plan:
- CH=4, SYNC_STAGES=2, deb_len=3, mode ch0=01; din_i[0] rises and holds -> edge_o[0] high exactly one cycle, 5 cycles after the first sampling edge; pend_o[0]=1, irq_o=1.
- deb_len=3; 3-cycle high glitch on din_i[1] with mode 11 -> no edge_o[1], level_o[1] stays 0. A 4-cycle pulse -> rise and fall pulses, pend_o[1]=1.
- mode ch2=10; full pulse on din_i[2] -> only the falling edge produces edge_o[2]. Mode 00 -> no edge_o, level_o still follows.
- pend_clr_i[0] asserted in the same cycle as a new edge_o[0] -> pend_o[0] stays 1. Clear in the next cycle -> pend_o[0]=0, irq_o=0.
- SYNC_STAGES=0, deb_len=0; din_i toggles every 2 cycles -> edge_o pulses 1 cycle after each change. Assert reset_ni low mid-count -> all outputs 0 immediately, no spurious edge after release while din_i=0.
- With STE_EDGE_CNT_EN, CNT_W=2: 5 qualifying edges on ch3 -> cnt_o[ch3]=3 (saturated). pend_clr_i[3] -> 0.
